// File: rtl/pr_ctx_pkg.sv
// pr_ctx_pkg: sequencer states, transfer directions and parameter defaults for pr_ctx.
package pr_ctx_pkg;
  localparam int PR_W = 16;
  localparam int PR_NREG = 8;
  localparam int PR_NBANK = 2;
  localparam int PR_NFLAG = 9;
  localparam logic CTX_SAVE = 1'b0;
  localparam logic CTX_RESTORE = 1'b1;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_NEXT, S_DONE} seq_state_e;
endpackage

// File: rtl/pr_ctx_seq.sv
// pr_ctx_seq: walks R0..R(NREG-1) of one bank, one memory handshake per register.
module pr_ctx_seq import pr_ctx_pkg::*; #(
  parameter int NREG = PR_NREG,
  parameter int BW = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          ctx_start,
  input  logic          ctx_dir,
  input  logic [BW-1:0] ctx_bank,
  input  logic          mem_ack,
  output logic          mem_req,
  output logic          busy,
  output logic          done,
  output logic          ld_en,
  output logic [AW-1:0] idx,
  output logic [BW-1:0] bank
);
  seq_state_e state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [BW-1:0] bank_q, bank_d;
  logic dir_q, dir_d;
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      bank_q <= '0;
      dir_q <= CTX_SAVE;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      bank_q <= bank_d;
      dir_q <= dir_d;
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    bank_d = bank_q;
    dir_d = dir_q;
    case (state_q)
      S_IDLE: if (ctx_start) begin
        state_d = S_REQ;
        idx_d = '0;
        bank_d = ctx_bank;
        dir_d = ctx_dir;
      end
      S_REQ: state_d = mem_ack ? S_NEXT : S_REQ;
      S_NEXT: begin
        state_d = (idx_q == AW'(NREG - 1)) ? S_DONE : S_REQ;
        idx_d = (idx_q == AW'(NREG - 1)) ? idx_q : idx_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    mem_req = state_q == S_REQ;
    busy = state_q != S_IDLE;
    done = state_q == S_DONE;
    ld_en = mem_req && mem_ack && dir_q == CTX_RESTORE;
    idx = idx_q;
    bank = bank_q;
  end
endmodule

// File: rtl/pr_ctx.sv
// pr_ctx: banked register file with MSB-first R0 flags and a context save/restore port.
// Define PR_CTX_SWAP_EN to make rd_swap return the R0 flags shifted right by W/2.
module pr_ctx import pr_ctx_pkg::*; #(
  parameter int W = PR_W,
  parameter int NREG = PR_NREG,
  parameter int NBANK = PR_NBANK,
  parameter int NFLAG = PR_NFLAG,
  localparam int AW = $clog2(NREG),
  localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic [BW-1:0]    bank_sel,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [W-1:0]     wr_data,
  input  logic [AW-1:0]    rd_addr,
  input  logic             rd_swap,
  output logic [W-1:0]     rd_data,
  input  logic [NFLAG-1:0] flag_we,
  input  logic [NFLAG-1:0] flag_d,
  output logic [NFLAG-1:0] r0_flags,
  input  logic             ctx_start,
  input  logic             ctx_dir,
  input  logic [BW-1:0]    ctx_bank,
  output logic             mem_req,
  input  logic             mem_ack,
  output logic [AW-1:0]    mem_idx,
  output logic [W-1:0]     mem_wdata,
  input  logic [W-1:0]     mem_rdata,
  output logic             busy,
  output logic             done
);
  logic [W-1:0] regs_q [NBANK][NREG];
  logic [W-1:0] regs_d [NBANK][NREG];
  logic [W-1:0] fmask_w, fval_w, rd_raw;
  logic [BW-1:0] bs, xb, seq_bank;
  logic ld_en;
  pr_ctx_seq #(.NREG(NREG), .BW(BW)) u_seq (
    .clk_sys(clk_sys), .rst(rst), .ctx_start(ctx_start), .ctx_dir(ctx_dir),
    .ctx_bank(ctx_bank), .mem_ack(mem_ack), .mem_req(mem_req), .busy(busy),
    .done(done), .ld_en(ld_en), .idx(mem_idx), .bank(seq_bank)
  );
  // A single-bank build still carries a 1-bit bank select; pin it to bank 0.
  assign bs = (NBANK > 1) ? bank_sel : '0;
  assign xb = (NBANK > 1) ? seq_bank : '0;
  assign mem_wdata = regs_q[xb][mem_idx];
  assign rd_raw = regs_q[bs][rd_addr];
  always_comb begin
    fmask_w = '0;
    fval_w = '0;
    r0_flags = '0;
    for (int i = 0; i < NFLAG; i++) begin
      fmask_w[W-1-i] = flag_we[i];
      fval_w[W-1-i] = flag_d[i];
      r0_flags[i] = regs_q[bs][0][W-1-i];
    end
  end
  always_comb begin
    regs_d = regs_q;
    if (ld_en) regs_d[xb][mem_idx] = mem_rdata;
    if (!busy) begin
      if (wr_en) regs_d[bs][wr_addr] = wr_data;
      regs_d[bs][0] = (regs_d[bs][0] & ~fmask_w) | (fval_w & fmask_w);
    end
  end
  always_ff @(posedge clk_sys) begin
    if (rst) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  end
`ifdef PR_CTX_SWAP_EN
  localparam logic [W-1:0] FMASK = ~({W{1'b1}} >> NFLAG);
  assign rd_data = (rd_swap && rd_addr == '0) ? (rd_raw & FMASK) >> (W / 2) : rd_raw;
`else
  logic unused_swap;
  assign unused_swap = rd_swap;
  assign rd_data = rd_raw;
`endif
endmodule

// File: tb/tb_pr_ctx.sv
// tb_pr_ctx: directed vector table plus hand-written transfer and reset sequences for pr_ctx.
module tb_pr_ctx;
  logic clk_sys = 1'b0, rst = 1'b1;
  logic bank_sel = 1'b0, wr_en = 1'b0, rd_swap = 1'b0;
  logic [2:0] wr_addr = '0, rd_addr = '0, mem_idx;
  logic [15:0] wr_data = '0, rd_data, mem_wdata, mem_rdata = '0;
  logic [8:0] flag_we = '0, flag_d = '0, r0_flags;
  logic ctx_start = 1'b0, ctx_dir = 1'b0, ctx_bank = 1'b0;
  logic mem_req, mem_ack = 1'b0, busy, done;
  int n_vec = 0, n_err = 0;

`ifdef PR_CTX_SWAP_EN
  localparam logic [15:0] SWAP_EXP = 16'h00FF;
`else
  localparam logic [15:0] SWAP_EXP = 16'hFF80;
`endif

  typedef struct {
    logic we; logic b; logic [2:0] wa; logic [15:0] wd; logic [2:0] ra; logic sw;
    logic [8:0] fwe; logic [8:0] fd; logic [15:0] erd; logic [8:0] efl;
  } vec_t;
  vec_t vt[11];

  pr_ctx dut (
    .clk_sys(clk_sys), .rst(rst), .bank_sel(bank_sel), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_swap(rd_swap), .rd_data(rd_data),
    .flag_we(flag_we), .flag_d(flag_d), .r0_flags(r0_flags), .ctx_start(ctx_start),
    .ctx_dir(ctx_dir), .ctx_bank(ctx_bank), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_idx(mem_idx), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .done(done)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic b, input logic [2:0] a, input logic [15:0] d);
    bank_sel = b; wr_addr = a; wr_data = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic b, input logic [2:0] a, input logic [15:0] e);
    bank_sel = b; rd_addr = a; rd_swap = 1'b0;
    tick();
    chk(nm, rd_data, e);
  endtask

  // Acks each request one cycle after it appears; meanwhile tries a port write and a second start.
  task automatic xfer(input logic dir, input logic b, output int dn_cyc);
    int k = 0;
    int dn = 0;
    bit seen = 0;
    dn_cyc = -1;
    mem_rdata = 16'hFFFF;
    ctx_start = 1'b1; ctx_dir = dir; ctx_bank = b;
    tick();
    ctx_start = 1'b0;
    bank_sel = b; wr_addr = 3'd2; wr_data = 16'hDEAD; wr_en = 1'b1;
    flag_we = 9'h1FF; flag_d = 9'h1FF;
    for (int cyc = 1; cyc <= 100 && dn == 0; cyc++) begin
      if (cyc == 5) begin ctx_start = 1'b1; ctx_dir = ~dir; end
      if (cyc == 6) ctx_start = 1'b0;
      if (done) begin
        dn = 1; dn_cyc = cyc; wr_en = 1'b0; flag_we = '0;
      end
      if (mem_req && !seen) begin
        chk("xfer_idx", 32'(mem_idx), k);
        if (dir == 1'b0) chk("save_wdata", 32'(mem_wdata), k);
        seen = 1;
      end else if (mem_req) begin
        mem_ack = 1'b1; mem_rdata = 16'h1000 + 16'(k);
      end else begin
        if (mem_ack) k++;
        mem_ack = 1'b0; seen = 0;
      end
      tick();
    end
    wr_en = 1'b0; flag_we = '0; mem_ack = 1'b0;
    chk("xfer_done_seen", dn, 1);
    chk("xfer_count", k, 8);
    chk("busy_after", 32'(busy), 0);
    chk("done_once", 32'(done), 0);
  endtask

  initial begin
    int dc;
    int dn;
    bit found;
    vt[0]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 1'b0, 9'h000, 9'h000, 16'h0000, 9'h000};
    vt[1]  = '{1'b1, 1'b1, 3'd3, 16'hBEEF, 3'd3, 1'b0, 9'h000, 9'h000, 16'hBEEF, 9'h000};
    vt[2]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 1'b0, 9'h000, 9'h000, 16'h0000, 9'h000};
    vt[3]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b0, 9'h101, 9'h1FF, 16'h8080, 9'h101};
    vt[4]  = '{1'b1, 1'b0, 3'd0, 16'h1234, 3'd0, 1'b0, 9'h001, 9'h001, 16'h9234, 9'h049};
    vt[5]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b0, 9'h1FF, 9'h1FF, 16'hFF80, 9'h1FF};
    vt[6]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b1, 9'h000, 9'h000, SWAP_EXP, 9'h1FF};
    vt[7]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b0, 9'h100, 9'h000, 16'hFF00, 9'h0FF};
    vt[8]  = '{1'b0, 1'b1, 3'd0, 16'h0000, 3'd3, 1'b1, 9'h000, 9'h000, 16'hBEEF, 9'h000};
    vt[9]  = '{1'b1, 1'b0, 3'd7, 16'hA5A5, 3'd7, 1'b0, 9'h000, 9'h000, 16'hA5A5, 9'h0FF};
    vt[10] = '{1'b1, 1'b1, 3'd0, 16'h4000, 3'd0, 1'b0, 9'h000, 9'h000, 16'h4000, 9'h002};

    tick(); tick();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_mem_idx", 32'(mem_idx), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_flags", 32'(r0_flags), 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      wr_en = vt[i].we; bank_sel = vt[i].b; wr_addr = vt[i].wa; wr_data = vt[i].wd;
      rd_addr = vt[i].ra; rd_swap = vt[i].sw; flag_we = vt[i].fwe; flag_d = vt[i].fd;
      tick();
      chk($sformatf("vec%0d_rd", i), 32'(rd_data), 32'(vt[i].erd));
      chk($sformatf("vec%0d_flags", i), 32'(r0_flags), 32'(vt[i].efl));
    end
    wr_en = 1'b0; flag_we = '0; rd_swap = 1'b0;

    for (int n = 0; n < 8; n++) wr(1'b0, 3'(n), 16'(n));
    xfer(1'b0, 1'b0, dc);
    chk("save_len", dc, 25);
    for (int n = 0; n < 8; n++) rd_chk($sformatf("save_b0_r%0d", n), 1'b0, 3'(n), 16'(n));

    xfer(1'b1, 1'b1, dc);
    chk("restore_len", dc, 25);
    for (int n = 0; n < 8; n++) rd_chk($sformatf("rest_b1_r%0d", n), 1'b1, 3'(n), 16'h1000 + 16'(n));
    for (int n = 0; n < 8; n++) rd_chk($sformatf("rest_b0_r%0d", n), 1'b0, 3'(n), 16'(n));

    found = 0;
    ctx_start = 1'b1; ctx_dir = 1'b0; ctx_bank = 1'b1;
    tick();
    ctx_start = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      if (mem_req && mem_idx == 3'd4) found = 1;
      else begin
        mem_ack = mem_req;
        tick();
      end
    end
    chk("abort_reached_idx4", 32'(found), 1);
    mem_ack = 1'b0; rst = 1'b1;
    tick();
    chk("abort_mem_req", 32'(mem_req), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_mem_idx", 32'(mem_idx), 0);
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) dn++;
      tick();
    end
    chk("abort_no_done", dn, 0);
    for (int b = 0; b < 2; b++)
      for (int n = 0; n < 8; n++) rd_chk($sformatf("abort_b%0d_r%0d", b, n), 1'(b), 3'(n), 16'h0000);
    chk("abort_flags", 32'(r0_flags), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
